ram_cmd_master: RTL and testbench
=================================

RAM_CMD_MASTER -- requirements
Module: ram_cmd_master

Interface
REQ-001 The block SHALL provide parameter ADDR_SIZE, default 8, giving the width of the address and data fields.
REQ-002 The block SHALL provide parameter TIMEOUT, default 15, giving the maximum number of RD_WAIT cycles without a response.
REQ-003 The block SHALL provide parameter CACHE_EN, default 1; when 1, address commands are skipped on a cache hit.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  a host request is present.
REQ-007 req_ready  out  1  the block can accept a request; high only in IDLE.
REQ-008 req_rw  in  1  request type: 0 = write, 1 = read.
REQ-009 req_addr  in  ADDR_SIZE  target memory address.
REQ-010 req_data  in  ADDR_SIZE  write data; ignored for reads.
REQ-011 cmd_word  out  ADDR_SIZE+2  command to the target: [9:8] opcode, [7:0] payload.
REQ-012 cmd_valid  out  1  cmd_word is valid this cycle; drives the target's rx_valid.
REQ-013 rsp_data  in  ADDR_SIZE  target read data (target dout).
REQ-014 rsp_valid  in  1  target read-data valid (target tx_valid).
REQ-015 rd_data  out  ADDR_SIZE  returned read data; holds its value between reads.
REQ-016 rd_valid  out  1  one-cycle pulse: rd_data has been updated.
REQ-017 timeout_err  out  1  one-cycle pulse: a read was abandoned.
REQ-018 busy  out  1  asserted whenever the state is not IDLE.

Function
REQ-019 Opcodes SHALL be: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-020 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
REQ-021 In IDLE, on req_valid && req_ready the block SHALL capture req_rw, req_addr and req_data; request inputs are ignored in every other cycle.
REQ-022 A captured write SHALL go to WR_DATA on a write-address cache hit, otherwise to WR_ADDR; a captured read SHALL go to RD_CMD on a read-address cache hit, otherwise to RD_ADDR.
REQ-023 Each of WR_ADDR, WR_DATA, RD_ADDR and RD_CMD SHALL last exactly one cycle, with cmd_valid=1 and cmd_word={opcode, payload} driven from flops.
- Payload is the captured address for address commands, the captured data for WR_DATA, and 0 for RD_CMD.
REQ-024 Transitions: WR_ADDR->WR_DATA, WR_DATA->IDLE, RD_ADDR->RD_CMD, RD_CMD->RD_WAIT.
REQ-025 cmd_valid SHALL be 0 in IDLE and RD_WAIT.
REQ-026 The target responds with rsp_valid no earlier than the cycle after the RD_CMD cycle, so rsp_valid SHALL be sampled only in RD_WAIT and is never stale.
REQ-027 In RD_WAIT, when rsp_valid=1 the block SHALL register rd_data<=rsp_data, pulse rd_valid in the next cycle (state IDLE, req_ready=1), and clear the wait counter.
REQ-028 In RD_WAIT, after TIMEOUT consecutive cycles with rsp_valid=0 the block SHALL pulse timeout_err in the next cycle, leave rd_data unchanged, invalidate both address caches and return to IDLE.
REQ-029 Wait counter width SHALL be $clog2(TIMEOUT+1), with no wrap-around.
REQ-030 Cache: wr_addr_q/wr_vld SHALL be updated when WR_ADDR issues and rd_addr_q/rd_vld when RD_ADDR issues; a hit requires the valid flag set, equal addresses and CACHE_EN=1.
REQ-031 Latency (1-cycle target):
- write hit: 1 command cycle;
- write miss: 2 command cycles;
- read miss: rd_valid 4 cycles after acceptance;
- read hit: rd_valid 3 cycles after acceptance.
REQ-032 A request SHALL be acceptable in the same cycle that rd_valid or timeout_err pulses.

Reset
REQ-033 When rst=1 at a clock edge, the following edge-outputs SHALL become:
- state=IDLE, req_ready=1, busy=0;
- cmd_valid=0, cmd_word=0;
- rd_data=0, rd_valid=0, timeout_err=0;
- wr_vld=0, rd_vld=0, wait counter=0.
REQ-034 Reset mid-operation SHALL abort the transaction: no further command, rd_valid or timeout_err pulse for it.

Structure
REQ-035 Package ram_cmd_pkg SHALL hold the four opcode constants and the state enumeration.
REQ-036 The block SHALL be a single module; no sub-module is required.

Verification
REQ-037 The bench SHALL drive the target as a RAM model that answers opcode 11 with 1-cycle latency and holds tx_valid until its next command.
REQ-038 Write 0x3C to address 0x12, then write 0x55 to address 0x12 -> cmd_word 0x012, 0x13C, then only 0x155 (cache hit).
REQ-039 Read address 0x12 after REQ-038 -> cmd_word 0x212, 0x300; rd_valid=1 with rd_data=0x55 on the 4th cycle after acceptance.
REQ-040 Second read of 0x12 -> only 0x300 issued; rd_valid on the 3rd cycle with rd_data=0x55.
REQ-041 Read with rsp_valid tied 0 -> timeout_err pulses after 15 wait cycles, rd_data is unchanged, and the next write to 0x12 reissues 0x012.
REQ-042 rst=1 during RD_CMD -> the next cycle is IDLE with cmd_valid=0 and no rd_valid.
REQ-043 req_valid held high while busy -> exactly one acceptance per IDLE cycle and no lost or duplicated commands.

Source files
------------

// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the RAM command master: target opcodes and FSM states.
package ram_cmd_pkg;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_CMD,
      RD_WAIT
   } state_e;

endpackage

// File: rtl/ram_cmd_master.sv
// Host-to-target command sequencer: turns read/write requests into opcode words,
// skips address commands on address-cache hits, and abandons unanswered reads.
module ram_cmd_master
   import ram_cmd_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15,
   parameter int CACHE_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_rw,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [ADDR_SIZE-1:0] req_data,
   output logic [ADDR_SIZE+1:0] cmd_word,
   output logic                 cmd_valid,
   input  logic [ADDR_SIZE-1:0] rsp_data,
   input  logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_SIZE-1:0] ZERO = '0;

   state_e                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [ADDR_SIZE-1:0]   data_q, data_d;
   logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
   logic                   wr_vld_q, wr_vld_d;
   logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
   logic                   rd_vld_q, rd_vld_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_SIZE+1:0]   cmd_word_q, cmd_word_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [ADDR_SIZE-1:0]   rd_data_q, rd_data_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   wr_hit, rd_hit;

   assign wr_hit = (CACHE_EN != 0) && wr_vld_q && (wr_addr_q == req_addr);
   assign rd_hit = (CACHE_EN != 0) && rd_vld_q && (rd_addr_q == req_addr);

   always_comb begin
      // NOTE: every _d starts from its hold value so no branch can leave one unassigned and infer a latch.
      state_d       = state_q;
      addr_d        = addr_q;
      data_d        = data_q;
      wr_addr_d     = wr_addr_q;
      wr_vld_d      = wr_vld_q;
      rd_addr_d     = rd_addr_q;
      rd_vld_d      = rd_vld_q;
      cnt_d         = cnt_q;
      cmd_word_d    = '0;
      cmd_valid_d   = 1'b0;
      rd_data_d     = rd_data_q;
      rd_valid_d    = 1'b0;
      timeout_err_d = 1'b0;

      // The command for the state being entered is registered here, so cmd_word comes straight from flops.
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d      = req_addr;
               data_d      = req_data;
               cmd_valid_d = 1'b1;
               if (!req_rw) begin
                  if (wr_hit) begin
                     state_d    = WR_DATA;
                     cmd_word_d = {OP_WR_DATA, req_data};
                  end else begin
                     state_d    = WR_ADDR;
                     cmd_word_d = {OP_WR_ADDR, req_addr};
                  end
               end else begin
                  if (rd_hit) begin
                     state_d    = RD_CMD;
                     cmd_word_d = {OP_RD_DATA, ZERO};
                  end else begin
                     state_d    = RD_ADDR;
                     cmd_word_d = {OP_RD_ADDR, req_addr};
                  end
               end
            end
         end
         WR_ADDR: begin
            wr_addr_d   = addr_q;
            wr_vld_d    = 1'b1;
            state_d     = WR_DATA;
            cmd_valid_d = 1'b1;
            cmd_word_d  = {OP_WR_DATA, data_q};
         end
         WR_DATA: state_d = IDLE;
         RD_ADDR: begin
            rd_addr_d   = addr_q;
            rd_vld_d    = 1'b1;
            state_d     = RD_CMD;
            cmd_valid_d = 1'b1;
            cmd_word_d  = {OP_RD_DATA, ZERO};
         end
         RD_CMD: begin
            state_d = RD_WAIT;
            cnt_d   = '0;
         end
         RD_WAIT: begin
            if (rsp_valid) begin
               rd_data_d  = rsp_data;
               rd_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // An abandoned read leaves the target in an unknown state, so drop both caches.
               timeout_err_d = 1'b1;
               wr_vld_d      = 1'b0;
               rd_vld_d      = 1'b0;
               cnt_d         = '0;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         wr_addr_q     <= '0;
         wr_vld_q      <= 1'b0;
         rd_addr_q     <= '0;
         rd_vld_q      <= 1'b0;
         cnt_q         <= '0;
         cmd_word_q    <= '0;
         cmd_valid_q   <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         wr_addr_q     <= wr_addr_d;
         wr_vld_q      <= wr_vld_d;
         rd_addr_q     <= rd_addr_d;
         rd_vld_q      <= rd_vld_d;
         cnt_q         <= cnt_d;
         cmd_word_q    <= cmd_word_d;
         cmd_valid_q   <= cmd_valid_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign cmd_word    = cmd_word_q;
   assign cmd_valid   = cmd_valid_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: a 1-cycle RAM target model plus scoreboards
// for issued command words and returned read data.
module tb_ram_cmd_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic [9:0] cmd_word;
   logic       cmd_valid;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       timeout_err;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int tmo_seen = 0;

   logic [9:0] cmd_q [$];
   logic [7:0] rdq   [$];

   // RAM target model
   logic [7:0] mem [256];
   logic [7:0] wa, ra, dout;
   logic       tx_valid, mute;

   ram_cmd_master #(.ADDR_SIZE(8), .TIMEOUT(15), .CACHE_EN(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_data(req_data),
      .cmd_word(cmd_word), .cmd_valid(cmd_valid),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      wa = '0; ra = '0; dout = '0; tx_valid = 1'b0;
   end

   always @(posedge clk) begin
      if (cmd_valid) begin
         case (cmd_word[9:8])
            2'b00: wa <= cmd_word[7:0];
            2'b01: mem[wa] <= cmd_word[7:0];
            2'b10: ra <= cmd_word[7:0];
            default: dout <= mem[ra];
         endcase
         tx_valid <= (cmd_word[9:8] == 2'b11);
      end
   end

   assign rsp_valid = tx_valid & ~mute;
   assign rsp_data  = dout;

   // Monitors: compare every command and read return against the scoreboards
   always @(negedge clk) begin
      if (cmd_valid) begin
         total++;
         assert (cmd_q.size() != 0) else begin
            bad++; $error("FAIL cmd_unexpected obs=%h exp=none", cmd_word);
         end
         if (cmd_q.size() != 0) begin
            logic [9:0] e;
            e = cmd_q.pop_front();
            total++;
            assert (cmd_word === e) else begin
               bad++; $error("FAIL cmd_word obs=%h exp=%h", cmd_word, e);
            end
         end
      end
      if (rd_valid) begin
         total++;
         assert (rdq.size() != 0) else begin
            bad++; $error("FAIL rd_unexpected obs=%h exp=none", rd_data);
         end
         if (rdq.size() != 0) begin
            logic [7:0] e;
            e = rdq.pop_front();
            total++;
            assert (rd_data === e) else begin
               bad++; $error("FAIL rd_data obs=%h exp=%h", rd_data, e);
            end
         end
      end
      if (timeout_err) tmo_seen++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic rw, input logic [7:0] a, input logic [7:0] d);
      req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
      chk("accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      @(negedge clk);
      for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
      chk("idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   // Called right after send(): returns the cycle (1 = cycle after acceptance) where sig rose.
   task automatic wait_rd(output int lat);
      lat = 1;
      @(negedge clk);
      while (!rd_valid && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic wait_tmo(output int lat);
      lat = 1;
      @(negedge clk);
      while (!timeout_err && lat < 40) begin @(negedge clk); lat++; end
   endtask

   int lat;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0; mute = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_word", 32'(cmd_word), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write miss then write hit to the same address
      cmd_q.push_back(10'h012); cmd_q.push_back(10'h13C);
      send(1'b0, 8'h12, 8'h3C);
      chk("wr_miss_busy", 32'(busy), 32'd1);
      wait_idle();
      cmd_q.push_back(10'h155);
      send(1'b0, 8'h12, 8'h55);
      wait_idle();
      chk("wr_hit_drained", 32'(cmd_q.size()), 32'd0);

      // Read miss: rd_valid on the 4th cycle after acceptance
      cmd_q.push_back(10'h212); cmd_q.push_back(10'h300); rdq.push_back(8'h55);
      send(1'b1, 8'h12, 8'h00);
      wait_rd(lat);
      chk("rd_miss_latency", 32'(lat), 32'd4);
      chk("rd_valid_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;

      // Read hit: only the read-data command, rd_valid on the 3rd cycle
      cmd_q.push_back(10'h300); rdq.push_back(8'h55);
      send(1'b1, 8'h12, 8'h00);
      wait_rd(lat);
      chk("rd_hit_latency", 32'(lat), 32'd3);
      @(posedge clk); #1;

      // Unanswered read: 15 wait cycles then a timeout pulse on cycle 18
      mute = 1'b1;
      cmd_q.push_back(10'h234); cmd_q.push_back(10'h300);
      send(1'b1, 8'h34, 8'h00);
      wait_tmo(lat);
      chk("tmo_latency", 32'(lat), 32'd18);
      chk("tmo_ready", 32'(req_ready), 32'd1);
      chk("tmo_rd_data_kept", 32'(rd_data), 32'h55);
      @(negedge clk);
      chk("tmo_single_pulse", 32'(timeout_err), 32'd0);
      @(posedge clk); #1;
      mute = 1'b0;
      chk("tmo_count", 32'(tmo_seen), 32'd1);

      // Caches were dropped: the write to 0x12 reissues its address
      cmd_q.push_back(10'h012); cmd_q.push_back(10'h177);
      send(1'b0, 8'h12, 8'h77);
      wait_idle();

      // Reset while in RD_CMD aborts the read
      cmd_q.push_back(10'h212); cmd_q.push_back(10'h300);
      send(1'b1, 8'h12, 8'h00);
      @(posedge clk); #1;
      chk("in_rd_cmd_word", 32'(cmd_word), 32'h300);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("abort_rd_data", 32'(rd_data), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_tmo", 32'(tmo_seen), 32'd1);

      // req_valid held high across busy periods: one acceptance per IDLE window
      req_rw = 1'b0; req_addr = 8'h40; req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_data = 8'(k);
         if (k == 0) cmd_q.push_back(10'h040);
         cmd_q.push_back({2'b01, 8'(k)});
         @(negedge clk);
         for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
         chk("held_accept", 32'(req_ready), 32'd1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      wait_idle();
      chk("held_drained", 32'(cmd_q.size()), 32'd0);

      // Read back confirms the last held write landed exactly once
      cmd_q.push_back(10'h240); cmd_q.push_back(10'h300); rdq.push_back(8'h03);
      send(1'b1, 8'h40, 8'h00);
      wait_rd(lat);
      chk("held_rd_latency", 32'(lat), 32'd4);
      repeat (3) @(posedge clk);
      #1;

      chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
      chk("rd_q_empty", 32'(rdq.size()), 32'd0);
      chk("final_tmo_count", 32'(tmo_seen), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
